hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Pipeline hazard controller for a classic 5-stage in-order core.
//
//   * Load-use detection between the instruction in ID and a load in EXE.
//     On a hit it inserts exactly one bubble: PC and IF/ID hold, and ID/EXE
//     is flushed. The decision is purely combinational, so it takes effect in
//     the same cycle.
//   * Multi-cycle mult/div tracking with a two-state FSM (IDLE / MD_BUSY) and
//     a 6-bit down-counter. While the unit is busy, any ID instruction that
//     touches the mult/div unit or HI/LO is stalled the same way as a
//     load-use.
//   * A taken branch/jump resolved in EXE flushes IF/ID and ID/EXE. It has
//     priority over every stall, because the stalled instructions are on the
//     wrong path anyway.
//   * Reset is synchronous and active-high. While rst is high every output
//     is forced to 0.
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN - adds the 32-bit saturating performance counters
//                        stall_cnt (cycles with PC_stall=1) and flush_cnt
//                        (cycles with EXE_redirect=1). When the macro is not
//                        defined, the ports and registers do not exist.
// ============================================================================
module hazard_ctrl #(
    parameter int MD_LAT = 32              // mult/div latency in cycles, 2..63
) (
    input  logic       clk,
    input  logic       rst,
    // ID stage source operands
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_rs_use,
    input  logic       ID_rt_use,
    input  logic       ID_md_use,
    // EXE stage producer information
    input  logic [4:0] IDEXE_rd,
    input  logic       IDEXE_RFWr,
    input  logic [3:0] IDEXE_DMRd,
    input  logic       EXE_redirect,
    input  logic       EXE_md_start,
    // Pipeline control
    output logic       PC_stall,
    output logic       IFID_stall,
    output logic       IFID_flush,
    output logic       IDEXE_stall,
    output logic       IDEXE_flush,
    output logic       md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    // The start cycle itself counts as the first cycle of the latency, so the
    // counter is loaded with one less than the full latency.
    localparam logic [5:0] MD_LOAD    = 6'(MD_LAT - 1);

    localparam logic [3:0] DMRD_NOP   = 4'b0000;
    localparam int         NUM_SRC    = 2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [5:0] r_md_cnt;
    logic [5:0] w_md_cnt_next;

    // ------------------------------------------------------------------------
    // Load-use detection
    // ------------------------------------------------------------------------
    // rs and rt are handled as a small array of source operands so that both
    // get exactly the same comparison logic.
    logic [NUM_SRC-1:0][4:0] w_src_reg;
    logic [NUM_SRC-1:0]      w_src_use;
    logic [NUM_SRC-1:0]      w_src_hit;
    logic                    w_load_in_exe;
    logic                    w_load_use;

    assign w_src_reg[0] = ID_rs;
    assign w_src_reg[1] = ID_rt;
    assign w_src_use[0] = ID_rs_use;
    assign w_src_use[1] = ID_rt_use;

    // A load whose destination is $zero never produces a real value, so it
    // cannot create a dependency.
    assign w_load_in_exe = (IDEXE_DMRd != DMRD_NOP) && IDEXE_RFWr
                        && (IDEXE_rd != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src_match
            assign w_src_hit[gi] = w_src_use[gi] && (w_src_reg[gi] == IDEXE_rd);
        end
    endgenerate

    assign w_load_use = w_load_in_exe && (|w_src_hit);

    // ------------------------------------------------------------------------
    // Mult/div stall and combined stall request
    // ------------------------------------------------------------------------
    logic w_md_busy;
    logic w_md_stall;
    logic w_stall_req;

    assign w_md_busy   = (r_state == ST_MD_BUSY);
    assign w_md_stall  = w_md_busy && ID_md_use;
    // Both stall sources produce the same one-cycle hold, so they are merged
    // into a single request.
    assign w_stall_req = w_load_use || w_md_stall;

    // Pipeline control outputs: reset masks everything, redirect beats stalls
    always_comb begin
        PC_stall    = 1'b0;
        IFID_stall  = 1'b0;
        IFID_flush  = 1'b0;
        IDEXE_stall = 1'b0;     // reserved for a future multi-cycle EXE
        IDEXE_flush = 1'b0;
        md_busy     = 1'b0;
        if (!rst) begin
            md_busy = w_md_busy;
            if (EXE_redirect) begin
                IFID_flush  = 1'b1;
                IDEXE_flush = 1'b1;
            end else if (w_stall_req) begin
                PC_stall    = 1'b1;
                IFID_stall  = 1'b1;
                IDEXE_flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Mult/div FSM
    // ------------------------------------------------------------------------
    // Next-state logic: start only from IDLE, count down while busy.
    // EXE_md_start is accepted even when EXE_redirect is high, because the
    // instruction in EXE is older than the redirect it resolves.
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            ST_IDLE: begin
                if (EXE_md_start) begin
                    w_state_next  = ST_MD_BUSY;
                    w_md_cnt_next = MD_LOAD;
                end
            end
            ST_MD_BUSY: begin
                // A start request seen here is ignored: the unit is single
                // issue and the running operation is never restarted.
                if (r_md_cnt <= 6'd1) begin
                    w_state_next  = ST_IDLE;
                    w_md_cnt_next = 6'd0;
                end else begin
                    w_md_cnt_next = r_md_cnt - 6'd1;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_md_cnt_next = 6'd0;
            end
        endcase
    end

    // State and counter registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_md_cnt <= 6'd0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters for stall cycles and redirect cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (PC_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (EXE_redirect && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    // Counters are outputs and are therefore also masked while rst is high
    assign stall_cnt = rst ? 32'd0 : r_stall_cnt;
    assign flush_cnt = rst ? 32'd0 : r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl - directed self-checking bench for hazard_ctrl (MD_LAT=32).
// Inputs change 1 ns after the rising edge, and outputs are compared 1 ns
// later, inside the same cycle. Outputs are compared as the vector
// {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy}.
// The performance-counter scenario is built only with HAZARD_PERF_CNT_EN.
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int MD_LAT = 32;

    // Expected output vectors {PC_stall,IFID_stall,IFID_flush,IDEXE_stall,IDEXE_flush,md_busy}
    localparam logic [5:0] EXP_NONE       = 6'b000000;
    localparam logic [5:0] EXP_STALL      = 6'b110010;
    localparam logic [5:0] EXP_REDIR      = 6'b001010;
    localparam logic [5:0] EXP_BUSY       = 6'b000001;
    localparam logic [5:0] EXP_BUSY_STALL = 6'b110011;
    localparam logic [5:0] EXP_BUSY_REDIR = 6'b001011;

    logic       clk;
    logic       rst;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_rs_use;
    logic       ID_rt_use;
    logic       ID_md_use;
    logic [4:0] IDEXE_rd;
    logic       IDEXE_RFWr;
    logic [3:0] IDEXE_DMRd;
    logic       EXE_redirect;
    logic       EXE_md_start;
    logic       PC_stall;
    logic       IFID_stall;
    logic       IFID_flush;
    logic       IDEXE_stall;
    logic       IDEXE_flush;
    logic       md_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int tests_run;
    int tests_failed;
    logic [5:0] obs;
    logic [5:0] exp_v;

    hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_rs_use    (ID_rs_use),
        .ID_rt_use    (ID_rt_use),
        .ID_md_use    (ID_md_use),
        .IDEXE_rd     (IDEXE_rd),
        .IDEXE_RFWr   (IDEXE_RFWr),
        .IDEXE_DMRd   (IDEXE_DMRd),
        .EXE_redirect (EXE_redirect),
        .EXE_md_start (EXE_md_start),
        .PC_stall     (PC_stall),
        .IFID_stall   (IFID_stall),
        .IFID_flush   (IFID_flush),
        .IDEXE_stall  (IDEXE_stall),
        .IDEXE_flush  (IDEXE_flush),
        .md_busy      (md_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ID_rs        = 5'd0;
        ID_rt        = 5'd0;
        ID_rs_use    = 1'b0;
        ID_rt_use    = 1'b0;
        ID_md_use    = 1'b0;
        IDEXE_rd     = 5'd0;
        IDEXE_RFWr   = 1'b0;
        IDEXE_DMRd   = 4'b0000;
        EXE_redirect = 1'b0;
        EXE_md_start = 1'b0;
    endtask

    task automatic drive_load_use_rs8();
        IDEXE_DMRd = 4'b0001;
        IDEXE_RFWr = 1'b1;
        IDEXE_rd   = 5'd8;
        ID_rs      = 5'd8;
        ID_rs_use  = 1'b1;
    endtask

    // Reset with every hazard input active must hold all outputs low
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        drive_load_use_rs8();
        EXE_redirect = 1'b1;
        EXE_md_start = 1'b1;
        ID_md_use    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
            tests_run++;
            if (obs !== EXP_NONE) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d] got %b want %b", i, obs, EXP_NONE);
            end
            tick();
        end
        rst = 1'b0;
        drive_idle();
        #1;
        obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
        tests_run++;
        if (obs !== EXP_NONE) begin
            tests_failed++;
            $display("FAIL reset_release got %b want %b", obs, EXP_NONE);
        end
        $display("[TB] test_reset done");
        tick();
    endtask

    // Load-use detection across rs/rt and each qualifying condition
    task automatic test_load_use();
        string name;
        for (int v = 0; v < 8; v++) begin
            drive_idle();
            drive_load_use_rs8();
            case (v)
                0: begin name = "lu_rs_hit";   exp_v = EXP_STALL; end
                1: begin name = "lu_rd_zero";  IDEXE_rd = 5'd0; ID_rs = 5'd0; exp_v = EXP_NONE; end
                2: begin name = "lu_not_load"; IDEXE_DMRd = 4'b0000; exp_v = EXP_NONE; end
                3: begin name = "lu_no_wr";    IDEXE_RFWr = 1'b0; exp_v = EXP_NONE; end
                4: begin name = "lu_rs_unused"; ID_rs_use = 1'b0; exp_v = EXP_NONE; end
                5: begin name = "lu_rt_hit";   ID_rs_use = 1'b0; ID_rt = 5'd8; ID_rt_use = 1'b1;
                          IDEXE_DMRd = 4'b0100; exp_v = EXP_STALL; end
                6: begin name = "lu_rt_unused"; ID_rs = 5'd3; ID_rt = 5'd8; ID_rt_use = 1'b0; exp_v = EXP_NONE; end
                default: begin name = "lu_reg_diff"; ID_rs = 5'd9; exp_v = EXP_NONE; end
            endcase
            #1;
            obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL %s got %b want %b", name, obs, exp_v);
            end
            $display("[TB] %s outputs=%b", name, obs);
            tick();
        end
        drive_idle();
    endtask

    // Redirect overrides a simultaneous load-use stall
    task automatic test_redirect();
        drive_idle();
        drive_load_use_rs8();
        EXE_redirect = 1'b1;
        #1;
        obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
        tests_run++;
        if (obs !== EXP_REDIR) begin
            tests_failed++;
            $display("FAIL redirect_prio got %b want %b", obs, EXP_REDIR);
        end
        $display("[TB] redirect_prio outputs=%b", obs);
        tick();
        drive_idle();
        EXE_redirect = 1'b1;
        #1;
        obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
        tests_run++;
        if (obs !== EXP_REDIR) begin
            tests_failed++;
            $display("FAIL redirect_alone got %b want %b", obs, EXP_REDIR);
        end
        $display("[TB] redirect_alone outputs=%b", obs);
        tick();
        drive_idle();
    endtask

    // Start pulse at cycle 0: busy cycles 1..31, idle from 32; a second
    // start at cycle 10 must be ignored
    task automatic test_md_busy();
        drive_idle();
        EXE_md_start = 1'b1;
        ID_md_use    = 1'b1;
        #1;
        obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
        tests_run++;
        if (obs !== EXP_NONE) begin
            tests_failed++;
            $display("FAIL md_cycle0 got %b want %b", obs, EXP_NONE);
        end
        tick();
        for (int c = 1; c <= MD_LAT + 1; c++) begin
            EXE_md_start = (c == 10);
            exp_v = (c <= MD_LAT - 1) ? EXP_BUSY_STALL : EXP_NONE;
            #1;
            obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL md_cycle%0d got %b want %b", c, obs, exp_v);
            end
            $display("[TB] md_cycle%0d outputs=%b", c, obs);
            tick();
        end
        drive_idle();
    endtask

    // Start together with redirect is accepted; check busy-window
    // interactions with md_use, load-use and redirect
    task automatic test_md_with_redirect();
        drive_idle();
        EXE_redirect = 1'b1;
        EXE_md_start = 1'b1;
        #1;
        obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
        tests_run++;
        if (obs !== EXP_REDIR) begin
            tests_failed++;
            $display("FAIL mdr_cycle0 got %b want %b", obs, EXP_REDIR);
        end
        tick();
        for (int c = 1; c <= MD_LAT; c++) begin
            drive_idle();
            case (c)
                1:  exp_v = EXP_BUSY;                     // busy, no md_use
                2:  begin ID_md_use = 1'b1; exp_v = EXP_BUSY_STALL; end
                3:  begin ID_md_use = 1'b1; drive_load_use_rs8(); exp_v = EXP_BUSY_STALL; end
                4:  begin ID_md_use = 1'b1; EXE_redirect = 1'b1; exp_v = EXP_BUSY_REDIR; end
                5:  begin drive_load_use_rs8(); exp_v = EXP_BUSY_STALL; end
                31: exp_v = EXP_BUSY;
                32: exp_v = EXP_NONE;
                default: exp_v = EXP_BUSY;
            endcase
            #1;
            obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL mdr_cycle%0d got %b want %b", c, obs, exp_v);
            end
            if (c <= 5 || c >= 31) $display("[TB] mdr_cycle%0d outputs=%b", c, obs);
            tick();
        end
        drive_idle();
    endtask

    // Reset at cycle 10 of the busy window aborts it; a new start gets a
    // full 31-cycle busy window
    task automatic test_reset_mid();
        drive_idle();
        EXE_md_start = 1'b1;
        tick();
        EXE_md_start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        #1;
        tests_run++;
        if (md_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_busy_before got %b want 1", md_busy);
        end
        rst = 1'b1;
        ID_md_use = 1'b1;
        drive_load_use_rs8();
        EXE_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
            tests_run++;
            if (obs !== EXP_NONE) begin
                tests_failed++;
                $display("FAIL rmid_in_reset[%0d] got %b want %b", i, obs, EXP_NONE);
            end
            tick();
        end
        rst = 1'b0;
        drive_idle();
        ID_md_use = 1'b1;
        #1;
        obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
        tests_run++;
        if (obs !== EXP_NONE) begin
            tests_failed++;
            $display("FAIL rmid_after_release got %b want %b", obs, EXP_NONE);
        end
        $display("[TB] rmid_after_release outputs=%b", obs);
        EXE_md_start = 1'b1;
        tick();
        EXE_md_start = 1'b0;
        for (int c = 1; c <= MD_LAT; c++) begin
            exp_v = (c <= MD_LAT - 1) ? EXP_BUSY_STALL : EXP_NONE;
            #1;
            obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, md_busy};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL rmid_cycle%0d got %b want %b", c, obs, exp_v);
            end
            if (c == 1 || c >= MD_LAT - 1) $display("[TB] rmid_cycle%0d outputs=%b", c, obs);
            tick();
        end
        drive_idle();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    // 3 load-use stalls and 2 redirects after reset, then saturation
    task automatic test_perf_cnt();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_load_use_rs8();
            tick();
            drive_idle();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            EXE_redirect = 1'b1;
            tick();
            drive_idle();
            tick();
        end
        #1;
        tests_run++;
        if (stall_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL perf_stall_cnt got %0d want 3", stall_cnt);
        end
        tests_run++;
        if (flush_cnt !== 32'd2) begin
            tests_failed++;
            $display("FAIL perf_flush_cnt got %0d want 2", flush_cnt);
        end
        $display("[TB] perf stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
        dut.r_stall_cnt = 32'hFFFF_FFFF;
        dut.r_flush_cnt = 32'hFFFF_FFFF;
        drive_load_use_rs8();
        tick();
        drive_idle();
        EXE_redirect = 1'b1;
        tick();
        drive_idle();
        #1;
        tests_run++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL perf_stall_sat got %h want ffffffff", stall_cnt);
        end
        tests_run++;
        if (flush_cnt !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL perf_flush_sat got %h want ffffffff", flush_cnt);
        end
        $display("[TB] perf_sat stall_cnt=%h flush_cnt=%h", stall_cnt, flush_cnt);
        tick();
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        drive_idle();
        tick();
        test_reset();
        test_load_use();
        test_redirect();
        test_md_busy();
        test_md_with_redirect();
        test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        // IDEXE_stall is part of every compared vector; one explicit check too
        tests_run++;
        if (IDEXE_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL idexe_stall got %b want 0", IDEXE_stall);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
